conv_row_feeder: RTL

- Upstream feeder for the 3x3 convolution PE.
- Accepts a raster pixel stream one pixel per cycle and buffers the three most recent image rows of LANES pixels each.
- For each complete 3-row window, drives the PE's 32 data lanes for three consecutive cycles (oldest row first) with init high.
- Stalls the input stream while a window is being emitted.

---
 rtl/conv_row_feeder_if.sv | 23 ++
 rtl/conv_row_feeder.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/conv_row_feeder_if.sv
// Pixel-stream-in / PE-row-out bus of conv_row_feeder.
// master = pixel source and PE side, slave = the feeder itself.
interface conv_row_feeder_if #(
    parameter int WIDTH = 9,
    parameter int LANES = 32
);
    logic [WIDTH-1:0]       pix_in;
    logic                   pix_valid;
    logic                   pix_ready;
    logic [LANES*WIDTH-1:0] data_out;
    logic                   init;
    logic                   frame_done;

    modport master (
        output pix_in, pix_valid,
        input  pix_ready, data_out, init, frame_done
    );

    modport slave (
        input  pix_in, pix_valid,
        output pix_ready, data_out, init, frame_done
    );
endinterface

// File: rtl/conv_row_feeder.sv
// Buffers the three latest raster rows and replays each 3-row window to the 3x3 conv PE.
// Optional vertical zero padding: define CONV_ROW_FEEDER_ZERO_PAD_EN.
module conv_row_feeder #(
    parameter int WIDTH    = 9,
    parameter int LANES    = 32,
    parameter int IMG_ROWS = 8
) (
    input  logic             clk,
    input  logic             rst_n,   // active-high synchronous reset despite the name
    conv_row_feeder_if.slave pix
);

    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int RW = $clog2(IMG_ROWS + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(LANES - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_ROWS - 1);
`ifdef CONV_ROW_FEEDER_ZERO_PAD_EN
    localparam logic [1:0] FILL_START = 2'd1;
`else
    localparam logic [1:0] FILL_START = 2'd0;
`endif

    typedef enum logic [1:0] {FILL, EMIT0, EMIT1, EMIT2} state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          col;
    logic [RW-1:0]          img_row;
    logic [1:0]             rows_filled;
    logic [1:0]             wptr;
    logic                   last_row;
    logic                   frame_done_q;
    logic [LANES*WIDTH-1:0] row_buf [3];
    logic [1:0]             rd_idx;

    logic xfer, row_end, frame_end, pad_start;

`ifdef CONV_ROW_FEEDER_ZERO_PAD_EN
    logic [2:0] zero_mask;   // buffer that reads as an all-zero padding row
    logic       pad_win;
`endif

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign xfer    = (state == FILL) && pix.pix_valid;
    assign row_end = xfer && (col == COL_LAST);
`ifdef CONV_ROW_FEEDER_ZERO_PAD_EN
    assign pad_start = (state == EMIT2) && last_row && !pad_win;
    assign frame_end = (state == EMIT2) && last_row && pad_win;
`else
    assign pad_start = 1'b0;
    assign frame_end = (state == EMIT2) && last_row;
`endif

    always_ff @(posedge clk) begin
        if (rst_n) state <= FILL;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FILL:  if (row_end && rows_filled >= 2'd2) state_nxt = EMIT0;
            EMIT0: state_nxt = EMIT1;
            EMIT1: state_nxt = EMIT2;
            EMIT2: state_nxt = pad_start ? EMIT0 : FILL;
        endcase
    end

    // NOTE: every register here uses <= so all reads see the pre-edge value, matching the hardware.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            col          <= '0;
            img_row      <= '0;
            rows_filled  <= FILL_START;
            wptr         <= 2'd0;
            last_row     <= 1'b0;
            frame_done_q <= 1'b0;
            // NOTE: the row buffers are cleared on reset so a restarted stream never shows stale pixels.
            for (int r = 0; r < 3; r++) row_buf[r] <= '0;
`ifdef CONV_ROW_FEEDER_ZERO_PAD_EN
            zero_mask    <= 3'b100;
            pad_win      <= 1'b0;
`endif
        end else begin
            frame_done_q <= 1'b0;
            if (xfer) begin
                row_buf[wptr][col*WIDTH +: WIDTH] <= pix.pix_in;
                col <= row_end ? '0 : col + CW'(1);
            end
            if (row_end) begin
                wptr    <= inc3(wptr);
                img_row <= img_row + RW'(1);
                if (rows_filled != 2'd3) rows_filled <= rows_filled + 2'd1;
                if (img_row == ROW_LAST) last_row <= 1'b1;
`ifdef CONV_ROW_FEEDER_ZERO_PAD_EN
                zero_mask[wptr] <= 1'b0;
`endif
            end
`ifdef CONV_ROW_FEEDER_ZERO_PAD_EN
            // Trailing pad window: rotate the oldest buffer in as a virtual all-zero newest row.
            // That same buffer stays the zero "oldest" row for the next frame's first window.
            if (pad_start) begin
                wptr            <= inc3(wptr);
                zero_mask[wptr] <= 1'b1;
                pad_win         <= 1'b1;
            end
            if (frame_end) pad_win <= 1'b0;
`endif
            if (frame_end) begin
                frame_done_q <= 1'b1;
                rows_filled  <= FILL_START;
                img_row      <= '0;
                last_row     <= 1'b0;
            end
        end
    end

    // wptr always addresses the oldest row, so the window reads wptr, wptr+1, wptr+2 (mod 3).
    always_comb begin
        rd_idx         = wptr;
        pix.pix_ready  = 1'b0;
        pix.init       = 1'b0;
        pix.data_out   = '0;
        pix.frame_done = frame_done_q;
        unique case (state)
            FILL:  pix.pix_ready = 1'b1;
            EMIT0: rd_idx = wptr;
            EMIT1: rd_idx = inc3(wptr);
            EMIT2: rd_idx = inc3(inc3(wptr));
        endcase
        if (state != FILL) begin
            pix.init     = 1'b1;
            pix.data_out = row_buf[rd_idx];
`ifdef CONV_ROW_FEEDER_ZERO_PAD_EN
            if (zero_mask[rd_idx]) pix.data_out = '0;
`endif
        end
    end

endmodule
